// File: rtl/game_round_controller.sv
// Round sequencer in front of the game counter: loads the seed, forwards mode
// requests over valid/ready, tallies finished rounds and halts on game over.
module game_round_controller #(
  parameter int COUNTER_WIDTH = 3,
  parameter int ROUND_LIMIT   = 15,
  parameter int ROUND_WIDTH   = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [COUNTER_WIDTH-1:0] seed,
  input  logic [1:0]               mode_req,
  input  logic                     mode_valid,
  output logic                     mode_ready,
  output logic [1:0]               control,
  output logic [COUNTER_WIDTH-1:0] initialValue,
  output logic                     INIT,
  input  logic                     WINNER,
  input  logic                     LOSSER,
  input  logic                     GAMEOVER,
  input  logic [1:0]               WHO,
  output logic                     round_done,
  output logic [1:0]               last_who,
  output logic                     last_win,
  output logic [ROUND_WIDTH-1:0]   rounds,
  output logic                     busy,
  output logic                     game_over
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ARM,
    S_RUN,
    S_HALT
  } state_t;

  localparam logic [ROUND_WIDTH-1:0] ROUND_LIMIT_W = ROUND_WIDTH'(ROUND_LIMIT);
  localparam logic [ROUND_WIDTH-1:0] ROUND_MAX     = '1;

  state_t                     r_state;
  state_t                     w_next_state;

  logic [COUNTER_WIDTH-1:0]   r_seed;
  logic [1:0]                 r_control;
  logic [COUNTER_WIDTH-1:0]   r_init_value;
  logic                       r_init;
  logic                       r_round_done;
  logic [1:0]                 r_last_who;
  logic                       r_last_win;
  logic [ROUND_WIDTH-1:0]     r_rounds;
  logic                       r_busy;
  logic                       r_game_over;

  logic                       w_start_game;
  logic                       w_round_end;
  logic                       w_game_end;
  logic                       w_mode_ready;
  logic                       w_accept;
  logic [ROUND_WIDTH-1:0]     w_rounds_inc;
  logic                       w_limit_hit;
  logic                       w_next_busy;

  // Counter status only matters while a round is actually running.
  assign w_start_game = ((r_state == S_IDLE) || (r_state == S_HALT)) && start;
  assign w_round_end  = (r_state == S_RUN) && (WINNER || LOSSER);
  assign w_game_end   = (r_state == S_RUN) && GAMEOVER;
  assign w_mode_ready = (r_state == S_RUN) && !WINNER && !LOSSER && !GAMEOVER;
  assign w_accept     = mode_valid && w_mode_ready;

  assign w_rounds_inc = (r_rounds == ROUND_MAX) ? r_rounds : r_rounds + ROUND_WIDTH'(1);
  assign w_limit_hit  = (w_rounds_inc == ROUND_LIMIT_W);

  // NOTE: every signal written here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: if (w_start_game) w_next_state = S_LOAD;
      S_LOAD: w_next_state = S_ARM;
      S_ARM:  w_next_state = S_RUN;
      S_RUN: begin
        if (w_round_end) begin
          w_next_state = (GAMEOVER || w_limit_hit) ? S_HALT : S_LOAD;
        end else if (w_game_end) begin
          w_next_state = S_HALT;
        end
      end
      S_HALT: if (w_start_game) w_next_state = S_LOAD;
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_next_busy = (w_next_state == S_LOAD) || (w_next_state == S_ARM) ||
                       (w_next_state == S_RUN);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Outputs are registered from the next state so they line up with the state
  // they describe (INIT high exactly while in LOAD, game_over while in HALT).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_seed       <= '0;
      r_control    <= 2'b00;
      r_init_value <= '0;
      r_init       <= 1'b0;
      r_round_done <= 1'b0;
      r_last_who   <= 2'b00;
      r_last_win   <= 1'b0;
      r_rounds     <= '0;
      r_busy       <= 1'b0;
      r_game_over  <= 1'b0;
    end else begin
      r_init       <= (w_next_state == S_LOAD);
      r_busy       <= w_next_busy;
      r_game_over  <= (w_next_state == S_HALT);
      r_round_done <= w_round_end;

      if (w_start_game) begin
        r_seed       <= seed;
        r_init_value <= seed;
      end else if (w_next_state == S_LOAD) begin
        r_init_value <= r_seed;
      end

      if (w_next_state == S_LOAD) begin
        r_control <= 2'b00;
      end else if (w_accept) begin
        r_control <= mode_req;
      end

      if (w_start_game) begin
        r_rounds <= '0;
      end else if (w_round_end) begin
        r_rounds <= w_rounds_inc;
      end

      // A simultaneous win and loss is scored as a win.
      if (w_round_end) begin
        r_last_who <= WHO;
        r_last_win <= WINNER;
      end
    end
  end

  assign mode_ready   = w_mode_ready;
  assign control      = r_control;
  assign initialValue = r_init_value;
  assign INIT         = r_init;
  assign round_done   = r_round_done;
  assign last_who     = r_last_who;
  assign last_win     = r_last_win;
  assign rounds       = r_rounds;
  assign busy         = r_busy;
  assign game_over    = r_game_over;

endmodule
